// File: rtl/cache_assoc_if.sv
// Bus bundle between the pipeline/memory environment and cache_assoc.
// slave  : the cache's view (takes processor requests, drives memory requests)
// master : the environment's view (processor + slow memory)
interface cache_assoc_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_assoc.sv
// cache_assoc: 1- or 2-way set-associative, write-back, write-allocate cache
// with a 30-bit word-addressed processor port and a 128-bit line memory port.
// Optional build macro CACHE_READ_ONLY_EN: read-only I-cache variant with no
// dirty bits, no write-back state, and processor writes ignored.
module cache_assoc #(
  parameter int SETS = 4,
  parameter int WAYS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;

`ifdef CACHE_READ_ONLY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALLOC = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WBACK = 2'd1, S_ALLOC = 2'd2} state_t;
`endif

  // Address split: [1:0] word, [IDX_W+1:2] set, rest tag
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag_in;
  assign off    = bus.proc_addr[1:0];
  assign idx    = bus.proc_addr[IDX_W+1:2];
  assign tag_in = bus.proc_addr[29:IDX_W+2];

  // Line storage; only the valid/dirty/LRU bits need reset
  logic             valid_q [WAYS][SETS];
`ifndef CACHE_READ_ONLY_EN
  logic             dirty_q [WAYS][SETS];
`endif
  logic             lru_q   [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [127:0]     data_q  [WAYS][SETS];

  state_t      state_q;
  logic        vic_q;
  logic        mem_read_q;
  logic [27:0] mem_addr_q;
`ifndef CACHE_READ_ONLY_EN
  logic        mem_write_q;
  logic [127:0] mem_wdata_q;
`endif

  // A simultaneous read and write is handled as a write
  logic rd, wr, req;
  assign rd = bus.proc_read;
`ifdef CACHE_READ_ONLY_EN
  assign wr = 1'b0;
`else
  assign wr = bus.proc_write;
`endif
  assign req = rd | wr;

  logic [WAYS-1:0] hit_vec;
  logic            hit, hit_w, vic, vic_dirty;

  // Tag compare across the ways and victim choice for a miss
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag_in);
    hit   = |hit_vec;
    hit_w = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;
    if (WAYS == 1)                  vic = 1'b0;
    else if (!valid_q[0][idx])      vic = 1'b0;
    else if (!valid_q[WAYS-1][idx]) vic = 1'b1;
    else                            vic = lru_q[idx];
`ifdef CACHE_READ_ONLY_EN
    vic_dirty = 1'b0;
`else
    vic_dirty = dirty_q[vic][idx];
`endif
  end

  assign bus.proc_stall = (req && !hit) || (state_q != S_IDLE);
  assign bus.proc_rdata = (rd && hit) ? data_q[hit_w][idx][{off, 5'b0} +: 32] : 32'h0;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = mem_addr_q;
`ifdef CACHE_READ_ONLY_EN
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;
`else
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_wdata  = mem_wdata_q;
`endif

  // Controller FSM: hit bookkeeping, miss sequencing, registered memory requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vic_q      <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
`ifndef CACHE_READ_ONLY_EN
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
`endif
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
`ifndef CACHE_READ_ONLY_EN
          dirty_q[w][s] <= 1'b0;
`endif
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              if (WAYS == 2) lru_q[idx] <= ~hit_w;
`ifndef CACHE_READ_ONLY_EN
              if (wr) dirty_q[hit_w][idx] <= 1'b1;
`endif
            end else begin
              vic_q <= vic;
`ifndef CACHE_READ_ONLY_EN
              if (vic_dirty) begin
                state_q     <= S_WBACK;
                mem_write_q <= 1'b1;
                mem_addr_q  <= {tag_q[vic][idx], idx};
                mem_wdata_q <= data_q[vic][idx];
              end else
`endif
              begin
                state_q    <= S_ALLOC;
                mem_read_q <= 1'b1;
                mem_addr_q <= {tag_in, idx};
              end
            end
          end
        end
`ifndef CACHE_READ_ONLY_EN
        S_WBACK: begin
          if (bus.mem_ready) begin
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {tag_in, idx};
            state_q     <= S_ALLOC;
          end
        end
`endif
        S_ALLOC: begin
          if (bus.mem_ready) begin
            valid_q[vic_q][idx] <= 1'b1;
`ifndef CACHE_READ_ONLY_EN
            dirty_q[vic_q][idx] <= 1'b0;
`endif
            mem_read_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line data and tags: refill on fill completion, word merge on write hit
  always_ff @(posedge clk) begin
    if (state_q == S_ALLOC && bus.mem_ready) begin
      data_q[vic_q][idx] <= bus.mem_rdata;
      tag_q[vic_q][idx]  <= tag_in;
    end else if (state_q == S_IDLE && wr && hit) begin
      data_q[hit_w][idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Scoreboard bench for cache_assoc (SETS=4, WAYS=2, memory latency 4 cycles).
module tb_cache_assoc;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cache_assoc_if bus ();
  cache_assoc #(.SETS(4), .WAYS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           is_wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  mem_exp_t     mem_q[$];
  logic [31:0]  rd_q[$];
  logic [127:0] mem_m [logic [27:0]];
  logic         prev_r = 1'b0;
  logic         prev_w = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory default: word k of line a holds 0xC0000000 + word address
  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [31:0] b;
    b = 32'hC000_0000 + {2'b00, a, 2'b00};
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Slow memory: pulses mem_ready four cycles after a request appears
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.mem_read || bus.mem_write)) begin
        repeat (3) @(negedge clk);
        if (rst_n && (bus.mem_read || bus.mem_write)) begin
          if (bus.mem_write) mem_m[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_m.exists(bus.mem_addr) ? mem_m[bus.mem_addr] : line_of(bus.mem_addr);
          bus.mem_ready = 1'b1;
          @(negedge clk);
          bus.mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations when a read completes or a memory request starts
  initial begin
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.proc_read && !bus.proc_write && !bus.proc_stall) begin
          if (rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rdata_unexpected: got %0h expected none", bus.proc_rdata);
          end else check("rdata", bus.proc_rdata, rd_q.pop_front());
        end
        if ((bus.mem_read && !prev_r) || (bus.mem_write && !prev_w)) begin
          check("mem_exclusive", bus.mem_read & bus.mem_write, 0);
          if (mem_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL mem_unexpected: got addr %0h expected no request", bus.mem_addr);
          end else begin
            e = mem_q.pop_front();
            check("mem_kind_is_write", bus.mem_write, e.is_wr);
            check("mem_addr", bus.mem_addr, e.addr);
            if (e.is_wr) check("mem_wdata", bus.mem_wdata, e.wdata);
          end
        end
      end
      prev_r = bus.mem_read;
      prev_w = bus.mem_write;
    end
  end

  // Wait (bounded) for stall to drop, then let the request complete on the edge
  task automatic wait_done(input string name);
    int k = 0;
    while (1) begin
      @(negedge clk);
      if (!bus.proc_stall) break;
      k++;
      if (k > 60) begin
        n_checks++; n_fail++;
        $display("FAIL %s_timeout: got stall=1 expected stall=0 within 60 cycles", name);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [29:0] a, input logic exp_miss, input logic [31:0] exp_data);
    rd_q.push_back(exp_data);
    bus.proc_addr = a;
    bus.proc_read = 1'b1;
    #1;
    check("stall_on_issue", bus.proc_stall, exp_miss);
    wait_done("read");
    bus.proc_read = 1'b0;
  endtask

  task automatic do_write_hit(input logic [29:0] a, input logic [31:0] d);
    bus.proc_addr  = a;
    bus.proc_wdata = d;
    bus.proc_write = 1'b1;
    #1;
    check("write_stall", bus.proc_stall, 0);
    check("write_no_mem", {bus.mem_read, bus.mem_write}, 0);
    wait_done("write");
    bus.proc_write = 1'b0;
  endtask

  task automatic push_mem(input bit w, input logic [27:0] a, input logic [127:0] d);
    mem_exp_t e;
    e.is_wr = w; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endtask

  initial begin
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall", bus.proc_stall, 0);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", bus.proc_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef CACHE_READ_ONLY_EN
    do_write_hit(30'h4, 32'h5555_5555);
    push_mem(0, 28'h1, '0);
    do_read(30'h4, 1'b1, 32'hC000_0004);
    do_read(30'h5, 1'b0, 32'hC000_0005);
`else
    push_mem(0, 28'h0, '0);
    do_read(30'h0, 1'b1, 32'hC000_0000);
    do_write_hit(30'h1, 32'hDEAD_BEEF);
    do_read(30'h1, 1'b0, 32'hDEAD_BEEF);
    push_mem(0, 28'h4, '0);
    do_read(30'h10, 1'b1, 32'hC000_0010);
    push_mem(1, 28'h0, {32'hC000_0003, 32'hC000_0002, 32'hDEAD_BEEF, 32'hC000_0000});
    push_mem(0, 28'h8, '0);
    do_read(30'h20, 1'b1, 32'hC000_0020);
    do_read(30'h10, 1'b0, 32'hC000_0010);
    push_mem(0, 28'hC, '0);
    do_read(30'h30, 1'b1, 32'hC000_0030);
    do_read(30'h10, 1'b0, 32'hC000_0010);
    push_mem(0, 28'h0, '0);
    do_read(30'h1, 1'b1, 32'hDEAD_BEEF);
    do_write_hit(30'h2, 32'h1234_5678);
    do_read(30'h10, 1'b0, 32'hC000_0010);
    // Dirty victim: reset lands while the write-back is outstanding
    push_mem(1, 28'h0, {32'hC000_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'hC000_0000});
    bus.proc_addr = 30'h20;
    bus.proc_read = 1'b1;
    repeat (2) @(negedge clk);
    check("wback_active", bus.mem_write, 1);
    #1;
    rst_n = 1'b0;
    bus.proc_read = 1'b0;
    #1;
    check("rst_wback_mem_write", bus.mem_write, 0);
    check("rst_wback_mem_read", bus.mem_read, 0);
    check("rst_wback_mem_addr", bus.mem_addr, 0);
    check("rst_wback_stall", bus.proc_stall, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_mem(0, 28'h4, '0);
    do_read(30'h10, 1'b1, 32'hC000_0010);
`endif
    repeat (8) @(posedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised successor to the single-configuration cache used as both the I- and D-cache between `RISCV_Pipeline` and the slow memories.
- Set-associative (1 or 2 ways), write-back, write-allocate cache.
- Processor side: 30-bit word address. Memory side: 128-bit line interface.
- Drop-in for either cache instance. The D-instance uses full read/write; the I-instance may be built read-only (see Optional Feature).

Parameters:
- SETS, 4, number of sets; power of two, 2..64; IDX_W = log2(SETS).
- WAYS, 2, associativity; legal values 1 (direct-mapped) or 2 (LRU).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- proc_read  input  1  processor read request, held until stall drops.
- proc_write  input  1  processor write request, held until stall drops.
- proc_addr  input  30  word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  input  32  write data.
- proc_rdata  output  32  read data, valid when read is asserted and stall is low.
- proc_stall  output  1  stall to pipeline.
- mem_read  output  1  line fill request.
- mem_write  output  1  line write-back request.
- mem_addr  output  28  line address (byte address [31:4]).
- mem_wdata  output  128  victim line.
- mem_rdata  input  128  fill line.
- mem_ready  input  1  one-cycle completion pulse from slow memory.

Behaviour:
- Storage per line: valid, dirty, tag (28-IDX_W bits), 128-bit data. Per set (WAYS=2): one LRU bit naming the least-recently-used way.
- Reset (async, any state, including mid-transaction):
  - all valid, dirty and LRU bits cleared; state goes to IDLE;
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0;
  - proc_rdata = 0, proc_stall = 0.
- Request: req = proc_read | proc_write. If both are asserted, the request is treated as a write.
- Hit: some way in the indexed set is valid with a matching tag.
- proc_stall is combinational: high when (req and not hit) or state != IDLE.
- Read hit: zero-latency. proc_rdata is selected combinationally in the same cycle; LRU is updated at the edge to point at the other way.
- Write hit: the selected 32-bit word is written at the edge, dirty is set, LRU is updated. No memory traffic.
- Miss victim selection:
  - WAYS=1: the indexed line.
  - WAYS=2: the first invalid way (way 0 before way 1); otherwise the LRU way.
- States:
  - IDLE:
    - on a miss with a dirty victim, go to WBACK: register mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line;
    - on a miss with a clean victim, go to ALLOC: register mem_read=1, mem_addr={proc_addr tag, index}.
  - WBACK: hold the outputs until mem_ready=1. On that edge:
    - deassert mem_write;
    - assert mem_read with mem_addr={proc_addr tag, index};
    - go to ALLOC.
  - ALLOC: hold mem_read until mem_ready=1. On that edge:
    - write mem_rdata into the victim way, set valid, clear dirty, set tag;
    - deassert mem_read; go to IDLE.
  - The next cycle in IDLE hits. A pending write completes as a normal write hit (dirty set).
- mem_read and mem_write are never high together. The request is dropped in the cycle after mem_ready is sampled. mem_ready seen in IDLE is ignored.
- Miss latency: 1 + memory latency (+ memory latency again if a write-back is needed), then the hit cycle.
- proc_addr and proc_wdata must be stable while stall is high. The cache does not latch them.
- With no request (req=0), nothing changes and proc_stall=0.

Optional Feature:
- Macro CACHE_READ_ONLY_EN.
- When defined:
  - no dirty bits and no WBACK state; mem_write tied 0, mem_wdata tied 0;
  - proc_write and proc_wdata are ignored (treated as no request); all misses go directly to ALLOC.
  - This is the I-cache build.
- When undefined: full write-back behaviour as above.

Test Plan (SETS=4, WAYS=2, memory latency 4 cycles):
- Reset then read proc_addr=0x0000000 -> stall=1; mem_read=1 with mem_addr=0x0000000; after mem_ready, the next cycle gives stall=0 and proc_rdata = fill word 0.
- Write 0xDEADBEEF to 0x0000001 after the fill -> stall=0 in the same cycle, no mem traffic; a read of 0x0000001 returns 0xDEADBEEF.
- Read 0x10, then 0x20 (all set 0, after the dirty 0x0 line) -> 0x10 fills way 1. 0x20 evicts way 0 (LRU): mem_write with mem_addr=0x0000000 and wdata word1=0xDEADBEEF, then mem_read with mem_addr=0x0000008.
- Read 0x10 after the previous case -> hit, no mem traffic; LRU is updated so the next conflict evicts 0x20's way.
- Assert rst_n=0 while in WBACK -> mem_write=0 immediately; after release, a read of 0x10 misses (valid cleared).
- CACHE_READ_ONLY_EN build: proc_write=1 to 0x4 -> stall=0, no mem traffic, memory contents unchanged on a later read.
